// File: rtl/fpu_issue_ctrl_if.sv
// Core-side request/response channels of the FPU issue controller.
//
// Handshake rule (both channels): the producer raises valid and keeps every
// payload signal stable until the cycle in which valid && ready is seen at a
// rising clock edge; that edge is the transfer. The producer never
// withdraws valid before the transfer, and ready may depend on state only,
// never on valid.
interface fpu_issue_ctrl_if #(
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [31:0]      req_rs1;
  logic [31:0]      req_rs2;
  logic [2:0]       req_rm;
  logic [TAG_W-1:0] req_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic [4:0]       rsp_flags;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_illegal;

  // Core side: issues requests, consumes responses.
  modport master (
    output req_valid, req_op, req_rs1, req_rs2, req_rm, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_tag, rsp_illegal
  );

  // Controller side.
  modport slave (
    input  req_valid, req_op, req_rs1, req_rs2, req_rm, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_tag, rsp_illegal
  );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// Issue controller for the fixed-latency FPU: accepts one request, holds the
// FPU drive for LAT cycles, captures result/flags, returns a response and
// keeps the sticky fflags accumulator.
module fpu_issue_ctrl #(
  parameter int TAG_W = 4,
  parameter int LAT   = 3
) (
  input  logic                clk,
  input  logic                rst,
  fpu_issue_ctrl_if.slave     bus,
  output logic [31:0]         o_fpu_fp1,
  output logic [31:0]         o_fpu_fp2,
  output logic [2:0]          o_fpu_frm,
  output logic [6:0]          o_fpu_funct7,
  input  logic [31:0]         i_fpu_result,
  input  logic [4:0]          i_fpu_flags,
  input  logic [2:0]          i_csr_frm,
  input  logic                i_fflags_clr,
  output logic [4:0]          o_fflags,
  output logic [1:0]          o_dbg_state
);
  localparam int         CNT_W   = $clog2(LAT + 1);
  localparam logic [6:0] F7_IDLE = 7'b1111111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_fp1;
  logic [31:0]      r_fp2;
  logic [2:0]       r_frm;
  logic [6:0]       r_funct7;
  logic [31:0]      r_result;
  logic [4:0]       r_flags;
  logic [TAG_W-1:0] r_tag;
  logic             r_illegal;
  logic [4:0]       r_fflags;

  logic [2:0]       w_rm;
  logic [6:0]       w_f7;
  logic             w_legal;
  logic             w_accept;
  logic             w_capture;
  logic             w_rsp_hs;
  logic             w_req_ready;
  logic             w_rsp_valid;

  // Decode the incoming request: resolve dynamic rounding and map op to funct7.
  always_comb begin
    w_rm = (bus.req_rm == 3'b111) ? i_csr_frm : bus.req_rm;
    case (bus.req_op)
      2'b00:   w_f7 = 7'b0000000;
      2'b01:   w_f7 = 7'b0000100;
      2'b10:   w_f7 = 7'b0001000;
      default: w_f7 = F7_IDLE;
    endcase
    w_legal = (bus.req_op != 2'b11) && (w_rm != 3'b101) &&
              (w_rm != 3'b110) && (w_rm != 3'b111);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // FSM next state and handshake strobes.
  always_comb begin
    w_next      = r_state;
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b0;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_rsp_hs    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid) begin
          w_accept = 1'b1;
          w_next   = w_legal ? S_EXEC : S_RESP;
        end
      end
      S_EXEC: begin
        if (r_cnt == CNT_W'(1)) begin
          w_capture = 1'b1;
          w_next    = S_RESP;
        end
      end
      S_RESP: begin
        w_rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          w_rsp_hs = 1'b1;
          w_next   = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: latch the FPU drive on accept, hold it through EXEC, then
  // capture the FPU output and park the drive back at idle values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_fp1     <= '0;
      r_fp2     <= '0;
      r_frm     <= '0;
      r_funct7  <= F7_IDLE;
      r_result  <= '0;
      r_flags   <= '0;
      r_tag     <= '0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_tag     <= bus.req_tag;
      r_illegal <= !w_legal;
      if (w_legal) begin
        r_cnt    <= CNT_W'(LAT);
        r_fp1    <= bus.req_rs1;
        r_fp2    <= bus.req_rs2;
        r_frm    <= w_rm;
        r_funct7 <= w_f7;
      end else begin
        r_result <= '0;
        r_flags  <= '0;
      end
    end else if (r_state == S_EXEC) begin
      r_cnt <= r_cnt - CNT_W'(1);
      if (w_capture) begin
        r_result <= i_fpu_result;
        r_flags  <= i_fpu_flags;
        r_fp1    <= '0;
        r_fp2    <= '0;
        r_frm    <= '0;
        r_funct7 <= F7_IDLE;
      end
    end
  end

  // Sticky fflags: clear first, then OR in flags of a legal response being
  // consumed, so flags arriving with a clear survive it.
  always_ff @(posedge clk) begin
    if (rst) r_fflags <= '0;
    else     r_fflags <= (i_fflags_clr ? 5'b0 : r_fflags) |
                         ((w_rsp_hs && !r_illegal) ? r_flags : 5'b0);
  end

  assign bus.req_ready   = w_req_ready;
  assign bus.rsp_valid   = w_rsp_valid;
  assign bus.rsp_result  = r_result;
  assign bus.rsp_flags   = r_flags;
  assign bus.rsp_tag     = r_tag;
  assign bus.rsp_illegal = r_illegal;
  assign o_fpu_fp1       = r_fp1;
  assign o_fpu_fp2       = r_fp2;
  assign o_fpu_frm       = r_frm;
  assign o_fpu_funct7    = r_funct7;
  assign o_fflags        = r_fflags;
  assign o_dbg_state     = r_state;
endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

Issue-side controller for the three-stage FPU. Accepts one floating-point request at a time from the core over a valid/ready handshake and translates it into the FPU's funct7/frm/operand drive. Holds that drive stable for the FPU's fixed latency, then captures result and flags, and returns them over a valid/ready response channel. Also maintains the sticky RISC-V `fflags` accumulator and resolves the dynamic rounding mode from the CSR.

## Interface
Parameters:
- `TAG_W`, 4: width of the request/response tag.
- `LAT`, 3: number of cycles the FPU drive is held before sampling `fpu_result`/`fpu_flags`. Must be ≥ 3.

Ports (reset is synchronous and active-high, on `clk` only):
- `clk` in 1: system clock.
- `rst` in 1: synchronous active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request.
- `req_op` in 2: operation: 00 ADD, 01 SUB, 10 MUL, 11 reserved.
- `req_rs1`, `req_rs2` in 32: IEEE-754 single-precision operands.
- `req_rm` in 3: rounding mode; 111 selects dynamic mode (`csr_frm`).
- `req_tag` in TAG_W: opaque tag, returned unchanged.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts response.
- `rsp_result` out 32: FPU result.
- `rsp_flags` out 5: {NV, DZ, OF, UF, NX}.
- `rsp_tag` out TAG_W: tag of the request.
- `rsp_illegal` out 1: request had a reserved op or an illegal rounding mode.
- `fpu_fp1`, `fpu_fp2` out 32: FPU operands.
- `fpu_frm` out 3: resolved rounding mode.
- `fpu_funct7` out 7: ADD 7'b0000000, SUB 7'b0000100, MUL 7'b0001000, idle 7'b1111111.
- `fpu_result` in 32: FPU output.
- `fpu_flags` in 5: FPU flags.
- `csr_frm` in 3: fcsr rounding mode.
- `fflags_clr` in 1: clear the sticky flags.
- `fflags` out 5: sticky accumulated flags.

## Operation
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, register operands, tag, resolved rm and funct7.
  - Resolved rm = `req_rm`, except when `req_rm`=111, in which case it is `csr_frm`.
  - The request is illegal if `req_op`=11 or the resolved rm is 101, 110 or 111.
  - Legal request → EXEC, with the cycle counter loaded to `LAT`.
  - Illegal request → RESP directly, with `rsp_illegal`=1, `rsp_result`=0, `rsp_flags`=0. The FPU drive stays at idle values.
- EXEC:
  - `req_ready`=0.
  - `fpu_fp1`/`fpu_fp2`/`fpu_frm`/`fpu_funct7` are held constant. The FPU selects its output path on the live funct7, so the drive must not change mid-op.
  - The counter decrements each cycle.
  - In the cycle where counter=1, capture `fpu_result` and `fpu_flags` at the clock edge, go to RESP, and return the FPU drive to idle (funct7 7'b1111111, operands 0, frm 0).
- RESP:
  - `rsp_valid`=1.
  - All `rsp_*` outputs are held stable until `rsp_ready`.
  - On handshake → IDLE. A new request is not accepted in the same cycle.
- `fflags` update, every cycle: next = (`fflags_clr` ? 0 : `fflags`) | (RESP & `rsp_ready` & !`rsp_illegal` ? `rsp_flags` : 0).
  - When clear and accumulate coincide, the new flags survive.
- Illegal responses never modify `fflags`.

## Timing
- Reset values:
  - state IDLE, counter 0.
  - `req_ready`=1, `rsp_valid`=0.
  - `rsp_result`/`rsp_flags`/`rsp_tag`/`rsp_illegal`=0.
  - `fpu_fp1`/`fpu_fp2`/`fpu_frm`=0, `fpu_funct7`=7'b1111111.
  - `fflags`=0.
- Legal op latency:
  - Request accepted at edge E0.
  - FPU drive is valid from E0 through E0+LAT.
  - `rsp_valid` rises after edge E0+LAT.
  - Minimum issue interval is LAT+2 cycles.
- Illegal op: `rsp_valid` rises after E0 + 1 cycle.
- `rst` asserted in any state, including mid-EXEC or mid-RESP with `rsp_ready` low:
  - all state returns to reset values at the next edge;
  - the in-flight op is dropped with no response;
  - `fflags` is cleared.
- `csr_frm` is sampled only at request acceptance. Changes during EXEC do not affect the in-flight op.

## Test plan
- ADD 0x3F800000 + 0x40000000, rm 000, tag 5:
  - `fpu_funct7`=0000000 held 3 cycles;
  - `rsp_result`=0x40400000, flags 00000, tag 5;
  - `rsp_valid` 4 cycles after acceptance.
- SUB 0x40400000 − 0x3F800000, rm 111, `csr_frm`=000: `fpu_frm`=000, `fpu_funct7`=0000100, `rsp_result`=0x40000000.
- MUL 0x7F800000 × 0x00000000:
  - `rsp_flags`=10000, `fflags`=10000 after handshake;
  - a following clean ADD leaves `fflags`=10000;
  - `fflags_clr` → 00000.
- `req_op`=11 and, separately, rm=101:
  - `rsp_illegal`=1 one cycle after acceptance;
  - `fpu_funct7` stays 1111111;
  - `fflags` unchanged.
- Backpressure: `rsp_ready`=0 for 5 cycles in RESP, then 1.
  - `rsp_*` stable throughout, `req_ready`=0.
  - Accept the next request in the cycle after the handshake.
- `rst` pulsed during EXEC cycle 2: no response, all outputs at reset values next cycle, next request completes normally.
